uart_rx: RTL
============

# uart_rx

Serial receiver that sits directly upstream of the command parser in the tester FPGA. It deserialises the host UART line (8N1, LSB first) and presents each good byte as `rx_data_o` with a one-cycle `new_rx_data_o` strobe. It is the sole source of command and payload bytes (`r`, `s`, `g`, `i`, `o`, `e`, `f`, `p`, nclks hi/lo bytes, scan bits). Line sampling uses a 2-flop synchroniser and a 3-sample majority vote at bit centre.

## Interface
- `CLKS_PER_BIT`, default 868: clk cycles per UART bit (100 MHz / 115200). Legal range is 8 or more; a smaller value is an elaboration error.
- `clk`  in  1  system clock
- `rstn`  in  1  reset, asynchronous, active-low
- `rx_i`  in  1  raw serial line, asynchronous to clk, idle high
- `rx_data_o`  out  8  last good byte; reset 0x00; held until the next good byte
- `new_rx_data_o`  out  1  one-clk pulse when `rx_data_o` is updated; reset 0
- `frame_err_o`  out  1  one-clk pulse on a bad stop bit; reset 0
- `busy_o`  out  1  high in any state other than IDLE; reset 0

## Operation
- Synchroniser: both flops reset to 1. `rx_s` is the second flop's output.
- Definitions:
  - `H = CLKS_PER_BIT/2` (integer division).
  - `cnt` is the in-bit counter, width `clog2(CLKS_PER_BIT)`. It runs 0..`CLKS_PER_BIT-1` and wraps to 0.
  - `bit_idx` is 3 bits wide.
- Vote: `rx_s` is sampled at `cnt` = H-1, H and H+1. The bit value is the majority of the 3 samples, available at `cnt == H+1`.
- States:
  - **IDLE**: `cnt` = 0. When `rx_s == 0`, go to START.
  - **START**: at `cnt == H+1`, if the vote is 1 (false start), go to IDLE with no output. Otherwise continue. At `cnt == CLKS_PER_BIT-1`, go to DATA with `cnt` = 0 and `bit_idx` = 0.
  - **DATA**: at `cnt == H+1`, shift the vote into the MSB of the shift register (shift right, so the byte assembles LSB first). At `cnt == CLKS_PER_BIT-1`, increment `bit_idx`. After bit 7, go to STOP.
  - **STOP**: at `cnt == H+1`:
    - Vote 1: load `rx_data_o` from the shift register, pulse `new_rx_data_o`, go to IDLE.
    - Vote 0: pulse `frame_err_o`, leave `rx_data_o` unchanged, go to WAIT_HIGH.
  - **WAIT_HIGH**: stay until `rx_s == 1`, then go to IDLE. This stops a break or stuck-low line from generating bytes.
- Early return to IDLE at the stop-bit centre gives half a bit of slack for back-to-back frames and baud mismatch.
- `new_rx_data_o` and `frame_err_o` are never high in the same cycle.
- Outputs are registered.
- Reset mid-frame: all state returns to IDLE immediately and outputs go to their reset values. The partial byte is discarded and no strobe is produced.

## Timing
- Let E be the clk edge on which the FSM leaves IDLE. The first START period (`cnt` = 0) follows E.
- The stop-bit vote is taken in period `9*CLKS_PER_BIT+H+1` after E.
- `new_rx_data_o` or `frame_err_o` is high for exactly the one period that starts at edge `E+9*CLKS_PER_BIT+H+2`.
- The synchroniser adds 2 edges of latency from the `rx_i` fall to `rx_s` low. The FSM sees `rx_s` low and leaves IDLE on the next edge.
- The earliest next start is detected in the IDLE period after the strobe.
- There is no backpressure. The consumer must accept each byte on its strobe cycle. The next strobe comes at least `9*CLKS_PER_BIT` cycles later.

## Structure
- State encodings (IDLE, START, DATA, STOP, WAIT_HIGH) go in the shared header alongside the existing `clog2` in `functions.vh`.
- Sub-module `sync_ff2`: a 2-flop bit synchroniser with a parameterised reset value (1 here). It is reusable for other async pins such as the DUT outputs.

## Test plan
With `CLKS_PER_BIT` = 16 (H = 8):
- Send 0x65 ('e'), then 0x00, then 0x0A back-to-back with no idle gap.
  - Required: three `new_rx_data_o` pulses carrying 0x65, 0x00, 0x0A.
  - Each pulse occurs at `E+154` relative to its own start edge E.
  - `frame_err_o` never asserts.
- Drive `rx_i` low for 3 clk, then high.
  - Required: FSM returns to IDLE at `cnt == 9` of START.
  - No strobe, no error, `busy_o` falls.
- Send 0x55 with a 1-clk inverted glitch at `cnt == H` in bit 3.
  - Required: `rx_data_o` = 0x55 (majority rejects the glitch).
- Send 0xA3 with the stop bit held low, line low for 40 clk, then send 0x31.
  - Required: one `frame_err_o` pulse, and `rx_data_o` keeps its previous value.
  - No strobe while the line is low.
  - Then `new_rx_data_o` with 0x31.
- Assert `rstn` low mid-DATA of 0xFF, release it, and let the line go idle, then send 0x72.
  - Required: outputs are 0 during reset.
  - No strobe for the aborted byte.
  - The next strobe carries 0x72.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and helpers for the UART receiver: FSM state encodings and clog2.
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } state_t;

  // Bits needed to count 0..v-1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'd1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/uart_rx_sync_ff2.sv
// Two-flop synchroniser for a single asynchronous input bit, reset value selectable.
module sync_ff2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rstn,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with 2-flop line synchroniser and 3-sample majority vote at bit centre.
module uart_rx
  import uart_rx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx_i,
  output logic [7:0] rx_data_o,
  output logic       new_rx_data_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output state_t     dbg_state
);

  if (CLKS_PER_BIT < 8) begin : g_bad_param
    $error("uart_rx: CLKS_PER_BIT must be 8 or more");
  end

  localparam int CW = clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] H_M1 = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] H    = CW'(CLKS_PER_BIT / 2);
  localparam logic [CW-1:0] H_P1 = CW'(CLKS_PER_BIT / 2 + 1);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic          rx_s;
  logic          samp_a;
  logic          samp_b;
  logic          vote;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  state_t        state;

  sync_ff2 #(.RST_VAL(1'b1)) u_sync (
    .clk  (clk),
    .rstn (rstn),
    .d    (rx_i),
    .q    (rx_s)
  );

  // Third sample is the live rx_s at cnt == H+1, so the vote is usable in that cycle.
  assign vote      = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);
  assign dbg_state = state;

  // Strobes carry no ready: the consumer takes rx_data_o on the new_rx_data_o cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      samp_a        <= 1'b1;
      samp_b        <= 1'b1;
      rx_data_o     <= '0;
      new_rx_data_o <= 1'b0;
      frame_err_o   <= 1'b0;
      busy_o        <= 1'b0;
    end else begin
      new_rx_data_o <= 1'b0;
      frame_err_o   <= 1'b0;
      if (cnt == H_M1) samp_a <= rx_s;
      if (cnt == H)    samp_b <= rx_s;

      case (state)
        ST_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state  <= ST_START;
            busy_o <= 1'b1;
          end
        end

        ST_START: begin
          if (cnt == H_P1 && vote) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
            cnt    <= '0;
          end else if (cnt == LAST) begin
            state   <= ST_DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_DATA: begin
          if (cnt == H_P1) shreg <= {vote, shreg[7:1]};
          if (cnt == LAST) begin
            cnt     <= '0;
            bit_idx <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) state <= ST_STOP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        // Leaving at the stop-bit centre leaves half a bit of slack for the next start.
        ST_STOP: begin
          if (cnt == H_P1) begin
            cnt <= '0;
            if (vote) begin
              rx_data_o     <= shreg;
              new_rx_data_o <= 1'b1;
              state         <= ST_IDLE;
              busy_o        <= 1'b0;
            end else begin
              frame_err_o <= 1'b1;
              state       <= ST_WAIT_HIGH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        ST_WAIT_HIGH: begin
          cnt <= '0;
          if (rx_s) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end

        default: begin
          state  <= ST_IDLE;
          cnt    <= '0;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
